// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock front end.
// Default cycle counts assume a 50 MHz system clock.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_st_e;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DB_CYC      = CLK_HZ / 50;   // 20 ms
    localparam int RPT_DLY_CYC = CLK_HZ / 2;    // 0.5 s
    localparam int RPT_PER_CYC = CLK_HZ / 10;   // 0.1 s

    localparam int NUM_KEYS  = 4;
    localparam int KEY_MODE  = 0;
    localparam int KEY_POS   = 1;
    localparam int KEY_INC   = 2;
    localparam int KEY_ALARM = 3;

    localparam logic [NUM_KEYS-1:0] RPT_MASK_DEF = 4'b0100;

endpackage

// File: rtl/key_event_if.sv
// Button bus: raw active-low pins in, debounced level and event pulses out.
interface key_event_if;
    logic [3:0] i_sw;
    logic [3:0] o_level;
    logic [3:0] o_press;
    logic [3:0] o_release;

    modport master (
        output i_sw,
        input  o_level,
        input  o_press,
        input  o_release
    );

    modport slave (
        input  i_sw,
        output o_level,
        output o_press,
        output o_release
    );
endinterface

// File: rtl/key_chan.sv
// One button channel: 2-flop synchronizer, debounce counter and hold/repeat FSM.
// Takes an active-low raw pin, produces active-high level plus one-cycle pulses.
module key_chan #(
    parameter int DB_CYC      = clock_pkg::DB_CYC,
    parameter int RPT_DLY_CYC = clock_pkg::RPT_DLY_CYC,
    parameter int RPT_PER_CYC = clock_pkg::RPT_PER_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic rpt_en_i,
    input  logic sw_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    import clock_pkg::*;

    localparam int DB_W     = $clog2(DB_CYC);
    localparam int HOLD_MAX = (RPT_DLY_CYC > RPT_PER_CYC) ? RPT_DLY_CYC : RPT_PER_CYC;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(RPT_DLY_CYC - 1);
    localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(RPT_PER_CYC - 1);

    if (DB_CYC < 2 || RPT_DLY_CYC < 2 || RPT_PER_CYC < 2) begin : g_param_check
        $error("key_chan: DB_CYC, RPT_DLY_CYC and RPT_PER_CYC must all be >= 2");
    end

    logic              sync1_q, sync2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              pressed_s;
    logic              rise, fall;
    hold_st_e          st_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              press_q, release_q;

    assign pressed_s = ~sync2_q;

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (pressed_s == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            sync1_q  <= sw_n_i;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    // FSM reacts to the level change on the same edge that registers it,
    // so the press pulse and the new level appear together.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (rise) begin
                        st_q       <= ST_HELD;
                        hold_cnt_q <= '0;
                        press_q    <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        st_q       <= ST_IDLE;
                        hold_cnt_q <= '0;
                        release_q  <= 1'b1;
                    end else if (hold_cnt_q == DLY_LAST) begin
                        // Non-repeating keys park here with the counter saturated.
                        if (rpt_en_i) begin
                            st_q       <= ST_REPEAT;
                            hold_cnt_q <= '0;
                            press_q    <= 1'b1;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (fall) begin
                        st_q       <= ST_IDLE;
                        hold_cnt_q <= '0;
                        release_q  <= 1'b1;
                    end else if (hold_cnt_q == PER_LAST) begin
                        hold_cnt_q <= '0;
                        press_q    <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    st_q       <= ST_IDLE;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_event.sv
// Four-key button front end for the clock controller.
// Each pin gets an independent key_chan; RPT_MASK selects auto-repeating keys.
module key_event #(
    parameter int         DB_CYC      = clock_pkg::DB_CYC,
    parameter int         RPT_DLY_CYC = clock_pkg::RPT_DLY_CYC,
    parameter int         RPT_PER_CYC = clock_pkg::RPT_PER_CYC,
    parameter logic [3:0] RPT_MASK    = clock_pkg::RPT_MASK_DEF
) (
    input logic        clk,
    input logic        rst,
    key_event_if.slave kif
);
    import clock_pkg::*;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        key_chan #(
            .DB_CYC      (DB_CYC),
            .RPT_DLY_CYC (RPT_DLY_CYC),
            .RPT_PER_CYC (RPT_PER_CYC)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .rpt_en_i  (RPT_MASK[k]),
            .sw_n_i    (kif.i_sw[k]),
            .level_o   (kif.o_level[k]),
            .press_o   (kif.o_press[k]),
            .release_o (kif.o_release[k])
        );
    end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: directed scenarios with fixed edge expectations plus
// randomized pin activity checked against a timestamp-based behavioural model.
module tb_key_event;

    localparam int         DB   = 4;
    localparam int         DLY  = 20;
    localparam int         PER  = 8;
    localparam logic [3:0] MASK = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    key_event_if kif ();

    key_event #(
        .DB_CYC      (DB),
        .RPT_DLY_CYC (DLY),
        .RPT_PER_CYC (PER),
        .RPT_MASK    (MASK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    // Leaves the DUT idle with reset released just after a rising edge.
    task automatic do_reset();
        kif.i_sw = 4'hF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got, exp;
        kif.i_sw = 4'hF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got = {kif.o_level, kif.o_press, kif.o_release};
        exp = 12'h000;
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_held got=%h exp=%h", got, exp);
        end
        rst = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk); #1;
            got = {kif.o_level, kif.o_press, kif.o_release};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_idle e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_press_release();
        logic [11:0] got, exp;
        do_reset();
        @(posedge clk); #1;
        kif.i_sw = 4'b1110;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk); #1;
            exp = {3'b000, 1'(e >= 6 && e < 36), 3'b000, 1'(e == 6), 3'b000, 1'(e == 36)};
            got = {kif.o_level, kif.o_press, kif.o_release};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL press_release e=%0d got=%h exp=%h", e, got, exp);
            end
            if (e == 30) kif.i_sw = 4'hF;
        end
    endtask

    task automatic test_bounce();
        logic [11:0] got, exp;
        do_reset();
        @(posedge clk); #1;
        kif.i_sw[1] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            exp = {2'b00, 1'(e >= 26), 1'b0, 2'b00, 1'(e == 26), 1'b0, 4'h0};
            got = {kif.o_level, kif.o_press, kif.o_release};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bounce e=%0d got=%h exp=%h", e, got, exp);
            end
            kif.i_sw[1] = (e < 20) ? 1'((e / 2) % 2) : 1'b0;
        end
    endtask

    task automatic test_repeat_release_win();
        logic [11:0] got, exp;
        logic        p2, lv;
        do_reset();
        @(posedge clk); #1;
        kif.i_sw = 4'b1010;
        for (int e = 1; e <= 75; e++) begin
            @(posedge clk); #1;
            p2 = (e == 6) || (e >= 26 && e <= 58 && ((e - 26) % 8) == 0);
            lv = (e >= 6 && e < 66);
            exp = {1'b0, lv, 1'b0, lv,
                   1'b0, p2, 1'b0, 1'(e == 6),
                   1'b0, 1'(e == 66), 1'b0, 1'(e == 66)};
            got = {kif.o_level, kif.o_press, kif.o_release};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL repeat_release e=%0d got=%h exp=%h", e, got, exp);
            end
            if (e == 60) kif.i_sw = 4'hF;
        end
    endtask

    task automatic test_simultaneous();
        logic [11:0] got, exp;
        do_reset();
        @(posedge clk); #1;
        kif.i_sw = 4'h0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            exp = {(e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0};
            got = {kif.o_level, kif.o_press, kif.o_release};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL simultaneous e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [11:0] got, exp;
        do_reset();
        @(posedge clk); #1;
        kif.i_sw = 4'b1011;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk); #1;
            if (e < 30)
                exp = {1'b0, 1'(e >= 6), 2'b00, 1'b0, 1'(e == 6 || e == 26), 2'b00, 4'h0};
            else if (e <= 35)
                exp = (e == 30) ? 12'h400 : 12'h000;
            else
                exp = {1'b0, 1'(e >= 41), 2'b00, 1'b0, 1'(e == 41), 2'b00, 4'h0};
            got = {kif.o_level, kif.o_press, kif.o_release};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_hold e=%0d got=%h exp=%h", e, got, exp);
            end
            if (e == 30) begin
                rst = 1'b1;
                #1;
                got = {kif.o_level, kif.o_press, kif.o_release};
                n_tests++;
                if (got !== 12'h000) begin
                    n_fail++;
                    $display("FAIL reset_async got=%h exp=000", got);
                end
            end
            if (e == 35) rst = 1'b0;
        end
    endtask

    // Model: a level flips once the last DB pin samples (seen two edges late)
    // all disagree with it and DB edges have passed since the previous flip;
    // repeats fall at press_time + DLY + k*PER for masked keys.
    task automatic test_random();
        bit          samp [4][DB+2];
        bit          mlvl [4];
        int          last_tog [4];
        int          press_t [4];
        int          hold_left [4];
        logic [3:0]  cur_sw, el, ep, er;
        logic [11:0] got, exp;
        bit          all_diff;
        int          d;
        do_reset();
        cur_sw = 4'hF;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < DB + 2; j++) samp[k][j] = 1'b0;
            mlvl[k] = 1'b0;
            last_tog[k] = 0;
            press_t[k] = 0;
            hold_left[k] = 0;
        end
        for (int t = 1; t <= 4000; t++) begin
            @(posedge clk); #1;
            el = '0; ep = '0; er = '0;
            for (int k = 0; k < 4; k++) begin
                for (int j = DB + 1; j > 0; j--) samp[k][j] = samp[k][j-1];
                samp[k][0] = ~cur_sw[k];
                all_diff = 1'b1;
                for (int j = 2; j < DB + 2; j++)
                    if (samp[k][j] == mlvl[k]) all_diff = 1'b0;
                if (all_diff && (t - last_tog[k] >= DB)) begin
                    mlvl[k] = ~mlvl[k];
                    last_tog[k] = t;
                    if (mlvl[k]) begin
                        ep[k] = 1'b1;
                        press_t[k] = t;
                    end else begin
                        er[k] = 1'b1;
                    end
                end else if (mlvl[k] && MASK[k]) begin
                    d = t - press_t[k];
                    if (d == DLY || (d > DLY && ((d - DLY) % PER) == 0)) ep[k] = 1'b1;
                end
                el[k] = mlvl[k];
            end
            exp = {el, ep, er};
            got = {kif.o_level, kif.o_press, kif.o_release};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random t=%0d got=%h exp=%h", t, got, exp);
            end
            for (int k = 0; k < 4; k++) begin
                if (hold_left[k] == 0) begin
                    cur_sw[k] = 1'($urandom_range(0, 1));
                    hold_left[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5))
                                                               : int'($urandom_range(6, 70));
                end
                hold_left[k]--;
            end
            kif.i_sw = cur_sw;
        end
    endtask

    initial begin
        kif.i_sw = 4'hF;
        test_reset();
        test_press_release();
        test_bounce();
        test_repeat_release_win();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
